// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
//   REG_WIDTH_DEF    : default PC/register width (32; 64 also legal)
//   RESET_VECTOR_DEF : PC loaded by reset (zero-extended to REG_WIDTH)
//   EXC_VECTOR_DEF   : PC loaded on an exception (zero-extended to REG_WIDTH)
//   pc_sel_e         : next-PC source selected by pc_target_calc
package pc_unit_pkg;

    localparam int          REG_WIDTH_DEF    = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/address bundle between the decode stage and the PC unit.
//   master : decode side, drives stall/exc/jump/branch controls, zero,
//            imm26 and rs_val; receives pc, inc_pc, link_addr, pcsrc,
//            misaligned
//   slave  : pc_unit side, the mirror image
interface pc_unit_if
    import pc_unit_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_DEF
) ();

    logic                 stall;
    logic                 exc;
    logic                 j;
    logic                 jal;
    logic                 jr;
    logic                 beq;
    logic                 bne;
    logic                 zero;
    logic [25:0]          imm26;
    logic [REG_WIDTH-1:0] rs_val;
    logic [REG_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0] inc_pc;
    logic [REG_WIDTH-1:0] link_addr;
    logic                 pcsrc;
    logic                 misaligned;

    modport master (
        output stall, exc, j, jal, jr, beq, bne, zero, imm26, rs_val,
        input  pc, inc_pc, link_addr, pcsrc, misaligned
    );

    modport slave (
        input  stall, exc, j, jal, jr, beq, bne, zero, imm26, rs_val,
        output pc, inc_pc, link_addr, pcsrc, misaligned
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target computation and source selection.
//   inc_pc        : pc + 4 of the current instruction
//   imm26, rs_val : jump field / branch offset and jr register
//   j,jal,jr,beq,bne,zero,stall,exc : decoded control
//   sel           : chosen source (exc > jr > j/jal > taken branch > seq)
//   target        : address for sel (inc_pc for SEL_SEQ)
//   redirect      : a jump or taken branch is requested and not stalled
//   jr_misaligned : rs_val low bits non-zero
// Stall-hold and delay-slot sequencing (PC_UNIT_DELAY_SLOT_EN) live in pc_unit.
module pc_target_calc
    import pc_unit_pkg::*;
#(
    parameter int                   REG_WIDTH  = REG_WIDTH_DEF,
    parameter logic [REG_WIDTH-1:0] EXC_VECTOR = REG_WIDTH'(EXC_VECTOR_DEF)
) (
    input  logic [REG_WIDTH-1:0] inc_pc,
    input  logic [25:0]          imm26,
    input  logic [REG_WIDTH-1:0] rs_val,
    input  logic                 j,
    input  logic                 jal,
    input  logic                 jr,
    input  logic                 beq,
    input  logic                 bne,
    input  logic                 zero,
    input  logic                 stall,
    input  logic                 exc,
    output pc_sel_e              sel,
    output logic [REG_WIDTH-1:0] target,
    output logic                 redirect,
    output logic                 jr_misaligned
);

    // Word offset of a branch: sign-extended imm16 scaled by 4.
    function automatic logic signed [REG_WIDTH-1:0] br_offset(input logic [15:0] imm);
        logic signed [REG_WIDTH-1:0] off;
        off = {{(REG_WIDTH-18){imm[15]}}, imm, 2'b00};
        return off;
    endfunction

    logic                 br_taken;
    logic [REG_WIDTH-1:0] br_target;
    logic [REG_WIDTH-1:0] j_target;
    logic [REG_WIDTH-1:0] jr_target;

    // Both branch flags together: taken if either condition holds.
    assign br_taken      = (beq & zero) | (bne & ~zero);
    assign br_target     = inc_pc + $unsigned(br_offset(imm26[15:0]));
    assign j_target      = {inc_pc[REG_WIDTH-1:28], imm26, 2'b00};
    assign jr_target     = {rs_val[REG_WIDTH-1:2], 2'b00};
    assign jr_misaligned = |rs_val[1:0];
    assign redirect      = (j | jal | jr | br_taken) & ~stall;

    always_comb begin
        sel    = SEL_SEQ;
        target = inc_pc;
        if (exc) begin
            sel    = SEL_EXC;
            target = EXC_VECTOR;
        end else if (jr) begin
            sel    = SEL_JR;
            target = jr_target;
        end else if (j | jal) begin
            sel    = SEL_J;
            target = j_target;
        end else if (br_taken) begin
            sel    = SEL_BR;
            target = br_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with MIPS-style jump/branch/jr redirection and exceptions.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pc <= RESET_VECTOR)
//   bus   : pc_unit_if.slave -- controls in; pc, inc_pc, link_addr,
//           pcsrc, misaligned out
// Build option: define PC_UNIT_DELAY_SLOT_EN for branch-delay-slot
// behaviour (pending target register, link_addr = pc + 8). Default build
// redirects on the next edge and link_addr = pc + 4.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                   REG_WIDTH    = REG_WIDTH_DEF,
    parameter logic [REG_WIDTH-1:0] RESET_VECTOR = REG_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [REG_WIDTH-1:0] EXC_VECTOR   = REG_WIDTH'(EXC_VECTOR_DEF)
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);

    logic [REG_WIDTH-1:0] pc_p0;
    logic                 mis_p0;
    logic [REG_WIDTH-1:0] inc_pc;
    logic [REG_WIDTH-1:0] target;
    logic [REG_WIDTH-1:0] next_pc;
    logic                 redirect;
    logic                 jr_misaligned;
    logic                 mis_d;
    pc_sel_e              sel;

    assign inc_pc = pc_p0 + REG_WIDTH'(4);

    pc_target_calc #(
        .REG_WIDTH  (REG_WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_calc (
        .inc_pc        (inc_pc),
        .imm26         (bus.imm26),
        .rs_val        (bus.rs_val),
        .j             (bus.j),
        .jal           (bus.jal),
        .jr            (bus.jr),
        .beq           (bus.beq),
        .bne           (bus.bne),
        .zero          (bus.zero),
        .stall         (bus.stall),
        .exc           (bus.exc),
        .sel           (sel),
        .target        (target),
        .redirect      (redirect),
        .jr_misaligned (jr_misaligned)
    );

`ifdef PC_UNIT_DELAY_SLOT_EN
    logic                 pend_vld_p0;
    logic                 pend_vld_d;
    logic                 pend_load;
    logic [REG_WIDTH-1:0] pend_tgt_p0;

    // While a target is pending the current instruction is the delay slot:
    // its redirect inputs are ignored.
    always_comb begin
        next_pc    = pc_p0;
        pend_vld_d = pend_vld_p0;
        pend_load  = 1'b0;
        if (bus.exc) begin
            next_pc    = EXC_VECTOR;
            pend_vld_d = 1'b0;
        end else if (!bus.stall) begin
            if (pend_vld_p0) begin
                next_pc    = pend_tgt_p0;
                pend_vld_d = 1'b0;
            end else begin
                next_pc = inc_pc;
                if (redirect) begin
                    pend_vld_d = 1'b1;
                    pend_load  = 1'b1;
                end
            end
        end
    end

    assign mis_d         = (sel == SEL_JR) & ~bus.stall & ~pend_vld_p0 & jr_misaligned;
    assign bus.link_addr = pc_p0 + REG_WIDTH'(8);

    // ---- stage p0: pending target (data only, qualified by pend_vld_p0)
    always_ff @(posedge clk) begin
        if (pend_load) begin
            pend_tgt_p0 <= target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_p0 <= 1'b0;
        end else begin
            pend_vld_p0 <= pend_vld_d;
        end
    end
`else
    // exc bypasses stall; otherwise stall holds, else take the selected target.
    assign next_pc       = (bus.exc || !bus.stall) ? target : pc_p0;
    assign mis_d         = (sel == SEL_JR) & ~bus.stall & jr_misaligned;
    assign bus.link_addr = inc_pc;
`endif

    // ---- stage p0: architectural PC and misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0  <= RESET_VECTOR;
            mis_p0 <= 1'b0;
        end else begin
            pc_p0  <= next_pc;
            mis_p0 <= mis_d;
        end
    end

    assign bus.pc         = pc_p0;
    assign bus.inc_pc     = inc_pc;
    assign bus.pcsrc      = redirect;
    assign bus.misaligned = mis_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; follows PC_UNIT_DELAY_SLOT_EN for expectations.
module tb_pc_unit;

    logic clk;
    logic rst_n;

    pc_unit_if #(.REG_WIDTH(32)) bus ();

    pc_unit #(.REG_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_mis_q[$];
    logic [31:0] last_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        bus.stall  = 1'b0;
        bus.exc    = 1'b0;
        bus.j      = 1'b0;
        bus.jal    = 1'b0;
        bus.jr     = 1'b0;
        bus.beq    = 1'b0;
        bus.bne    = 1'b0;
        bus.zero   = 1'b0;
        bus.imm26  = 26'd0;
        bus.rs_val = 32'd0;
    endtask

    // Expected state after the coming edge goes into the scoreboard, then is
    // popped and compared once the DUT has clocked.
    task automatic step(input string tag, input logic [31:0] p, input logic m);
        logic [31:0] ep;
        logic [31:0] em;
        exp_pc_q.push_back(p);
        exp_mis_q.push_back({31'd0, m});
        last_exp = p;
        @(posedge clk);
        #1;
        ep = exp_pc_q.pop_front();
        em = exp_mis_q.pop_front();
        chk({tag, ".pc"}, bus.pc, ep);
        chk({tag, ".mis"}, {31'd0, bus.misaligned}, em);
    endtask

    task automatic set_pc(input logic [31:0] addr);
        clear();
        bus.jr     = 1'b1;
        bus.rs_val = addr;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("set_pc.slot", last_exp + 32'd4, 1'b0);
        clear();
`endif
        step("set_pc", addr, 1'b0);
        clear();
    endtask

    initial begin
        clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.pc", bus.pc, 32'h0);
        chk("rst.mis", {31'd0, bus.misaligned}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_exp = 32'h0;
        #1;
        chk("rst.inc_pc", bus.inc_pc, 32'h4);
`ifdef PC_UNIT_DELAY_SLOT_EN
        chk("rst.link", bus.link_addr, 32'h8);
`else
        chk("rst.link", bus.link_addr, 32'h4);
`endif
        step("seq1", 32'h4, 1'b0);
        step("seq2", 32'h8, 1'b0);

        // beq taken, offset -1 word: target == pc
        set_pc(32'h100);
        bus.beq = 1'b1; bus.zero = 1'b1; bus.imm26 = 26'h000FFFF;
        #1 chk("beq.pcsrc", {31'd0, bus.pcsrc}, 32'h1);
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("beq.slot", 32'h104, 1'b0);
        clear();
`endif
        step("beq", 32'h100, 1'b0);
        clear();

        // bne with zero set is not taken
        bus.bne = 1'b1; bus.zero = 1'b1; bus.imm26 = 26'h0000040;
        #1 chk("bne_nt.pcsrc", {31'd0, bus.pcsrc}, 32'h0);
        step("bne_nt", 32'h104, 1'b0);
        clear();

        // beq+bne together, zero clear: bne condition takes it, offset -2 words
        bus.beq = 1'b1; bus.bne = 1'b1; bus.zero = 1'b0; bus.imm26 = 26'h000FFFE;
        #1 chk("bboth.pcsrc", {31'd0, bus.pcsrc}, 32'h1);
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("bboth.slot", 32'h108, 1'b0);
        clear();
`endif
        step("bboth", 32'h100, 1'b0);
        clear();

        // jal: link address and jump target
        set_pc(32'h0040_0000);
        bus.jal = 1'b1; bus.imm26 = 26'h0000010;
        #1;
`ifdef PC_UNIT_DELAY_SLOT_EN
        chk("jal.link", bus.link_addr, 32'h0040_0008);
        step("jal.slot", 32'h0040_0004, 1'b0);
        // a jump presented in the delay slot is ignored
        bus.jal = 1'b0; bus.j = 1'b1; bus.imm26 = 26'h00003FF;
`else
        chk("jal.link", bus.link_addr, 32'h0040_0004);
`endif
        step("jal", 32'h0000_0040, 1'b0);
        clear();

        // jump keeps upper nibble of pc+4
        set_pc(32'h3000_0000);
        bus.j = 1'b1; bus.imm26 = 26'h3FF_FFFF;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("j_hi.slot", 32'h3000_0004, 1'b0);
        clear();
`endif
        step("j_hi", 32'h3FFF_FFFC, 1'b0);
        clear();

        // jr outranks j
        bus.j = 1'b1; bus.jr = 1'b1; bus.rs_val = 32'h2000; bus.imm26 = 26'h0000123;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("jr_prio.slot", 32'h4000_0000, 1'b0);
        clear();
`endif
        step("jr_prio", 32'h2000, 1'b0);
        clear();

        // stalled misaligned jr is not accepted
        bus.stall = 1'b1; bus.jr = 1'b1; bus.rs_val = 32'h1003;
        #1 chk("jr_stall.pcsrc", {31'd0, bus.pcsrc}, 32'h0);
        step("jr_stall", 32'h2000, 1'b0);
        // accepted misaligned jr: flag for exactly one cycle
        bus.stall = 1'b0;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("jr_mis.slot", 32'h2004, 1'b1);
        clear();
        step("jr_mis", 32'h1000, 1'b0);
`else
        step("jr_mis", 32'h1000, 1'b1);
        clear();
        step("jr_mis.after", 32'h1004, 1'b0);
`endif

        // wrap-around
        set_pc(32'hFFFF_FFFC);
        #1 chk("wrap.inc_pc", bus.inc_pc, 32'h0);
        step("wrap", 32'h0, 1'b0);

        // taken branch, stall twice, then exc with stall
        bus.beq = 1'b1; bus.zero = 1'b1; bus.imm26 = 26'h0000010;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("exc_br.slot", 32'h4, 1'b0);
        bus.stall = 1'b1;
        step("exc_stall1", 32'h4, 1'b0);
        step("exc_stall2", 32'h4, 1'b0);
`else
        step("exc_br", 32'h44, 1'b0);
        bus.stall = 1'b1;
        #1 chk("exc_stall.pcsrc", {31'd0, bus.pcsrc}, 32'h0);
        step("exc_stall1", 32'h44, 1'b0);
        step("exc_stall2", 32'h44, 1'b0);
`endif
        bus.exc = 1'b1;
        step("exc", 32'h8000_0180, 1'b0);
        clear();
        step("exc.after", 32'h8000_0184, 1'b0);

        // reset pulse mid-cycle while a redirect is in flight
        bus.j = 1'b1; bus.imm26 = 26'h0000100;
`ifdef PC_UNIT_DELAY_SLOT_EN
        step("rst_mid.slot", 32'h8000_0188, 1'b0);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.pc", bus.pc, 32'h0);
        chk("rst_mid.mis", {31'd0, bus.misaligned}, 32'h0);
        rst_n = 1'b1;
        clear();
        last_exp = 32'h0;
        step("rst_mid.next", 32'h4, 1'b0);
        step("rst_mid.next2", 32'h8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, PC/register width; legal values 32 or 64.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000 (zero-extended to REG_WIDTH), PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h8000_0180 (zero-extended), PC value on exception.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have stall  input  1  hold PC; ignore j/jal/jr/beq/bne this cycle.
REQ-007 SHALL have exc  input  1  exception request; overrides everything except reset.
REQ-008 SHALL have j, jal, jr, beq, bne  input  1 each  decoded control for the instruction at pc.
REQ-009 SHALL have zero  input  1  ALU equality flag.
REQ-010 SHALL have imm26  input  26  instruction bits [25:0]; branch offset is imm26[15:0].
REQ-011 SHALL have rs_val  input  REG_WIDTH  jr target register value.
REQ-012 SHALL have pc  output  REG_WIDTH  registered fetch address.
REQ-013 SHALL have inc_pc  output  REG_WIDTH  pc + 4, combinational.
REQ-014 SHALL have link_addr  output  REG_WIDTH  return address for jal (pc + 8 with delay slot, pc + 4 without).
REQ-015 SHALL have pcsrc  output  1  combinational: redirect taken this cycle (j|jal|jr|beq&zero|bne&~zero), gated low by stall.
REQ-016 SHALL have misaligned  output  1  registered one-cycle flag: accepted jr with rs_val[1:0] != 0.

Function
REQ-017 Branch target SHALL be inc_pc + (sign-extended imm26[15:0] << 2), REG_WIDTH-bit modular, carry discarded.
REQ-018 Jump target SHALL be {inc_pc[REG_WIDTH-1:28], imm26, 2'b00}.
REQ-019 jr target SHALL be {rs_val[REG_WIDTH-1:2], 2'b00}.
REQ-020 Next-PC priority SHALL be: exc -> EXC_VECTOR; stall -> hold; jr; j/jal; taken beq/bne; else inc_pc.
REQ-021 Multiple of j/jal/jr asserted SHALL resolve jr first, then j/jal; beq and bne both asserted SHALL be taken iff the selected condition holds for either.
REQ-022 pc wrap-around from all-ones-minus-3 SHALL yield 0 without flagging.
REQ-023 misaligned SHALL assert in the cycle after an accepted misaligned jr and deassert the following cycle unless repeated.
REQ-024 exc asserted together with stall SHALL load EXC_VECTOR and clear any pending redirect.

Reset
REQ-025 On rst_n low, asynchronously: pc = RESET_VECTOR, misaligned = 0, pending redirect cleared.
REQ-026 Reset mid-redirect SHALL discard the redirect; first post-reset fetch SHALL be RESET_VECTOR.

Configuration
REQ-027 Macro PC_UNIT_DELAY_SLOT_EN SHALL select MIPS branch-delay-slot behaviour.
REQ-028 With PC_UNIT_DELAY_SLOT_EN defined: an accepted redirect SHALL store the target in a pending register with a valid bit; pc SHALL advance to inc_pc (delay slot), and on the next non-stalled cycle load the pending target; redirect inputs during the delay slot SHALL be ignored; stall in the delay slot SHALL hold pc and pending state.
REQ-029 Without PC_UNIT_DELAY_SLOT_EN: an accepted redirect SHALL load the target into pc on the next edge; no pending register exists; link_addr = pc + 4.

Structure
REQ-030 A shared package SHALL hold REG_WIDTH default, RESET_VECTOR, EXC_VECTOR, and the next-PC select enumeration (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC).
REQ-031 Target computation SHALL be a combinational sub-module pc_target_calc (branch/jump/jr targets and select); pc_unit holds all registers.

Verification
REQ-032 Reset release, no control -> pc 0x0, 0x4, 0x8 on successive edges.
REQ-033 pc=0x100, beq=1, zero=1, imm26[15:0]=0xFFFF -> target 0x100; no-slot: next pc 0x100; slot: 0x104 then 0x100.
REQ-034 pc=0x0040_0000, jal=1, imm26=0x0000010 -> target 0x0000_0040; link_addr 0x0040_0004 (no slot) / 0x0040_0008 (slot).
REQ-035 jr=1, rs_val=0x1003 -> target 0x1000, misaligned high exactly one cycle later.
REQ-036 Slot mode: branch taken, then stall=1 for 2 cycles in delay slot, then exc=1 -> pc holds 2 cycles, then 0x8000_0180, pending cleared.
REQ-037 rst_n pulsed low mid-cycle with pending redirect -> pc immediately 0x0; next pc 0x4.
